// File: rtl/mult16_array_pkg.sv
// rtl/mult16_array_pkg.sv - shared helpers for the pipelined array multiplier
// Purpose: stage-count arithmetic and the Baugh-Wooley correction constant.
// Contents:
//   MAX_W         widest operand the helpers support
//   ceil_div()    rounded-up integer division, used for the array stage count
//   bw_correction() constant with bits w and 2w-1 set for signed operands, zero otherwise
package mult16_array_pkg;

    localparam int MAX_W = 64;

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    // Baugh-Wooley needs +2^w and +2^(2w-1) on top of the partially inverted rows.
    function automatic logic [2*MAX_W-1:0] bw_correction(input int w, input bit sgn);
        logic [2*MAX_W-1:0] one;
        logic [2*MAX_W-1:0] c;
        one = {{(2*MAX_W-1){1'b0}}, 1'b1};
        c   = '0;
        if (sgn) begin
            c = (one << w) | (one << (2*w - 1));
        end
        return c;
    endfunction

endpackage

// File: rtl/mult_array_stage.sv
// rtl/mult_array_stage.sv - one registered group of partial-product rows
// Purpose: adds ROWS shifted partial-product rows (starting at row ROW_BASE)
//          into the incoming running sum and registers sum and operands.
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-high clear
//   sum_i    in   running sum from the previous stage (2*W)
//   a_i      in   multiplicand travelling with the sum (W)
//   b_i      in   multiplier travelling with the sum (W)
//   sum_o    out  registered running sum including this stage's rows
//   a_o      out  registered multiplicand
//   b_o      out  registered multiplier
module mult_array_stage
    import mult16_array_pkg::*;
#(
    parameter int W        = 16,
    parameter int SIGNED   = 0,
    parameter int ROW_BASE = 0,
    parameter int ROWS     = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [2*W-1:0] sum_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic [2*W-1:0] sum_o,
    output logic [W-1:0]   a_o,
    output logic [W-1:0]   b_o
);

    // Carry-propagate chain: chain[r+1] = chain[r] + row r of this group.
    logic [2*W-1:0] chain [0:ROWS];
    logic [2*W-1:0] sum_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;

    assign chain[0] = sum_i;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        localparam int I = ROW_BASE + r;
        logic [W-1:0] pp;

        // Signed rows invert the bits where exactly one operand index is the
        // sign position; the sign-by-sign bit stays true.
        if (SIGNED != 0 && I == W - 1) begin : g_msb_row
            assign pp = {a_i[W-1] & b_i[I], ~(a_i[W-2:0] & {(W-1){b_i[I]}})};
        end else if (SIGNED != 0) begin : g_sgn_row
            assign pp = {~(a_i[W-1] & b_i[I]), a_i[W-2:0] & {(W-1){b_i[I]}}};
        end else begin : g_uns_row
            assign pp = a_i & {W{b_i[I]}};
        end

        assign chain[r+1] = chain[r] + ({{W{1'b0}}, pp} << I);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            sum_q <= chain[ROWS];
            a_q   <= a_i;
            b_q   <= b_i;
        end
    end

    assign sum_o = sum_q;
    assign a_o   = a_q;
    assign b_o   = b_q;

endmodule

// File: rtl/mult16_array.sv
// rtl/mult16_array.sv - pipelined array multiplier with selectable output slice
// Purpose: one operand pair per clock, product slice out after 1+S cycles,
//          S = ceil(W/ROWS_PER_STAGE); no backpressure.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high clear of every pipeline register
//   in_valid   in   a/b valid this cycle
//   a          in   multiplicand (W)
//   b          in   multiplier (W)
//   out_valid  out  product valid this cycle
//   product    out  full_product[OUT_LSB+OUT_W-1:OUT_LSB]
module mult16_array
    import mult16_array_pkg::*;
#(
    parameter int W              = 16,
    parameter int SIGNED         = 0,
    parameter int ROWS_PER_STAGE = 4,
    parameter int OUT_LSB        = 0,
    parameter int OUT_W          = 2*W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    output logic [OUT_W-1:0] product
);

    localparam int S = ceil_div(W, ROWS_PER_STAGE);
    localparam logic [2*MAX_W-1:0] CORR_FULL = bw_correction(W, SIGNED != 0);
    localparam logic [2*W-1:0]     CORR      = CORR_FULL[2*W-1:0];

    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic         valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            a_q     <= a;
            b_q     <= b;
            valid_q <= in_valid;
        end
    end

    // The correction constant seeds the running sum, so no extra adder is needed.
    logic [2*W-1:0] sum_pipe [0:S];
    logic [W-1:0]   a_pipe   [0:S];
    logic [W-1:0]   b_pipe   [0:S];

    assign sum_pipe[0] = CORR;
    assign a_pipe[0]   = a_q;
    assign b_pipe[0]   = b_q;

    for (genvar s = 0; s < S; s++) begin : g_stage
        // The last group takes whatever rows remain.
        localparam int NROWS = ((s + 1) * ROWS_PER_STAGE > W) ? (W - s * ROWS_PER_STAGE)
                                                             : ROWS_PER_STAGE;
        mult_array_stage #(
            .W        (W),
            .SIGNED   (SIGNED),
            .ROW_BASE (s * ROWS_PER_STAGE),
            .ROWS     (NROWS)
        ) u_stage (
            .clk   (clk),
            .reset (reset),
            .sum_i (sum_pipe[s]),
            .a_i   (a_pipe[s]),
            .b_i   (b_pipe[s]),
            .sum_o (sum_pipe[s+1]),
            .a_o   (a_pipe[s+1]),
            .b_o   (b_pipe[s+1])
        );
    end

    // Valid shifts alongside the array registers, one bit per array stage.
    logic [S-1:0] vpipe_q;
    logic [S-1:0] vpipe_d;
    logic [S:0]   vshift;

    assign vshift  = {vpipe_q, valid_q};
    assign vpipe_d = vshift[S-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vpipe_q <= '0;
        end else begin
            vpipe_q <= vpipe_d;
        end
    end

    assign out_valid = vpipe_q[S-1];
    assign product   = sum_pipe[S][OUT_LSB +: OUT_W];

    // Operands leaving the last stage and bits outside the slice go nowhere.
    logic unused_bits;
    assign unused_bits = ^{a_pipe[S], b_pipe[S], sum_pipe[S], vshift[S]};

endmodule

// File: tb/tb_mult16_array.sv
// tb/tb_mult16_array.sv - scoreboard bench over five multiplier configurations
module tb_mult16_array;

    localparam int L_U0  = 5;
    localparam int L_S0  = 5;
    localparam int L_IIR = 6;
    localparam int L_R1  = 17;
    localparam int L_RW  = 2;

    typedef struct {
        logic [63:0] val;
        int          cyc;
    } sb_t;

    logic        clk;
    logic        reset;
    logic        vin;
    logic [15:0] a16, b16;
    logic [17:0] a18, b18;

    logic        ov_u0, ov_s0, ov_iir, ov_r1, ov_rw;
    logic [31:0] p_u0, p_s0, p_r1, p_rw;
    logic [17:0] p_iir;

    int n_cmp;
    int n_bad;
    int cyc;

    sb_t q_u0[$];
    sb_t q_s0[$];
    sb_t q_iir[$];
    sb_t q_r1[$];
    sb_t q_rw[$];

    mult16_array #(.W(16), .SIGNED(0), .ROWS_PER_STAGE(4), .OUT_LSB(0), .OUT_W(32)) u_u0 (
        .clk(clk), .reset(reset), .in_valid(vin), .a(a16), .b(b16),
        .out_valid(ov_u0), .product(p_u0));

    mult16_array #(.W(16), .SIGNED(1), .ROWS_PER_STAGE(4), .OUT_LSB(0), .OUT_W(32)) u_s0 (
        .clk(clk), .reset(reset), .in_valid(vin), .a(a16), .b(b16),
        .out_valid(ov_s0), .product(p_s0));

    mult16_array #(.W(18), .SIGNED(1), .ROWS_PER_STAGE(4), .OUT_LSB(16), .OUT_W(18)) u_iir (
        .clk(clk), .reset(reset), .in_valid(vin), .a(a18), .b(b18),
        .out_valid(ov_iir), .product(p_iir));

    mult16_array #(.W(16), .SIGNED(1), .ROWS_PER_STAGE(1), .OUT_LSB(0), .OUT_W(32)) u_r1 (
        .clk(clk), .reset(reset), .in_valid(vin), .a(a16), .b(b16),
        .out_valid(ov_r1), .product(p_r1));

    mult16_array #(.W(16), .SIGNED(0), .ROWS_PER_STAGE(16), .OUT_LSB(0), .OUT_W(32)) u_rw (
        .clk(clk), .reset(reset), .in_valid(vin), .a(a16), .b(b16),
        .out_valid(ov_rw), .product(p_rw));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] model(input longint x, input longint y, input int w,
                                          input bit sg, input int lsb, input int ow);
        longint sx, sy, p;
        sx = x;
        sy = y;
        if (sg) begin
            if (x >= (longint'(1) << (w - 1))) sx = x - (longint'(1) << w);
            if (y >= (longint'(1) << (w - 1))) sy = y - (longint'(1) << w);
        end
        p = (sx * sy) >>> lsb;
        return p & ((longint'(1) << ow) - 1);
    endfunction

    task automatic push_all(input logic [63:0] eu, input logic [63:0] es, input logic [63:0] ei,
                            input logic [63:0] er1, input logic [63:0] erw);
        sb_t e;
        e.cyc = cyc;
        e.val = eu;  q_u0.push_back(e);
        e.val = es;  q_s0.push_back(e);
        e.val = ei;  q_iir.push_back(e);
        e.val = er1; q_r1.push_back(e);
        e.val = erw; q_rw.push_back(e);
    endtask

    task automatic drive_one(input bit v, input logic [15:0] x16, input logic [15:0] y16,
                             input logic [17:0] x18, input logic [17:0] y18);
        @(negedge clk);
        vin = v; a16 = x16; b16 = y16; a18 = x18; b18 = y18;
        if (v) begin
            push_all(model(x16, y16, 16, 0, 0, 32), model(x16, y16, 16, 1, 0, 32),
                     model(x18, y18, 18, 1, 16, 18), model(x16, y16, 16, 1, 0, 32),
                     model(x16, y16, 16, 0, 0, 32));
        end
    endtask

    // Directed pair with hand-derived expectations (unsigned / signed / IIR).
    task automatic drive_exp(input logic [15:0] x16, input logic [15:0] y16,
                             input logic [17:0] x18, input logic [17:0] y18,
                             input logic [63:0] eu, input logic [63:0] es, input logic [63:0] ei);
        @(negedge clk);
        vin = 1'b1; a16 = x16; b16 = y16; a18 = x18; b18 = y18;
        push_all(eu, es, ei, es, eu);
    endtask

    task automatic drain();
        int left;
        @(negedge clk);
        vin = 1'b0;
        for (int i = 0; i < 60; i++) begin
            left = q_u0.size() + q_s0.size() + q_iir.size() + q_r1.size() + q_rw.size();
            if (left == 0) break;
            @(negedge clk);
        end
        check_eq("drain empty", 64'(q_u0.size() + q_s0.size() + q_iir.size()
                                    + q_r1.size() + q_rw.size()), 64'd0);
    endtask

    sb_t e_u0, e_s0, e_iir, e_r1, e_rw;

    always @(negedge clk) if (ov_u0) begin
        if (q_u0.size() == 0) check_eq("u0 extra", 64'd1, 64'd0);
        else begin
            e_u0 = q_u0.pop_front();
            check_eq("u0 data", {32'd0, p_u0}, e_u0.val);
            check_eq("u0 latency", 64'(cyc), 64'(e_u0.cyc + L_U0));
        end
    end

    always @(negedge clk) if (ov_s0) begin
        if (q_s0.size() == 0) check_eq("s0 extra", 64'd1, 64'd0);
        else begin
            e_s0 = q_s0.pop_front();
            check_eq("s0 data", {32'd0, p_s0}, e_s0.val);
            check_eq("s0 latency", 64'(cyc), 64'(e_s0.cyc + L_S0));
        end
    end

    always @(negedge clk) if (ov_iir) begin
        if (q_iir.size() == 0) check_eq("iir extra", 64'd1, 64'd0);
        else begin
            e_iir = q_iir.pop_front();
            check_eq("iir data", {46'd0, p_iir}, e_iir.val);
            check_eq("iir latency", 64'(cyc), 64'(e_iir.cyc + L_IIR));
        end
    end

    always @(negedge clk) if (ov_r1) begin
        if (q_r1.size() == 0) check_eq("r1 extra", 64'd1, 64'd0);
        else begin
            e_r1 = q_r1.pop_front();
            check_eq("r1 data", {32'd0, p_r1}, e_r1.val);
            check_eq("r1 latency", 64'(cyc), 64'(e_r1.cyc + L_R1));
        end
    end

    always @(negedge clk) if (ov_rw) begin
        if (q_rw.size() == 0) check_eq("rw extra", 64'd1, 64'd0);
        else begin
            e_rw = q_rw.pop_front();
            check_eq("rw data", {32'd0, p_rw}, e_rw.val);
            check_eq("rw latency", 64'(cyc), 64'(e_rw.cyc + L_RW));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        vin   = 1'b0;
        a16 = '0; b16 = '0; a18 = '0; b18 = '0;

        repeat (2) @(negedge clk);
        check_eq("reset ov u0", {63'd0, ov_u0}, 64'd0);
        check_eq("reset prod u0", {32'd0, p_u0}, 64'd0);
        check_eq("reset ov iir", {63'd0, ov_iir}, 64'd0);
        check_eq("reset prod iir", {46'd0, p_iir}, 64'd0);
        reset = 1'b0;

        drive_exp(16'hFFFF, 16'hFFFF, 18'h10000, 18'h08000, 64'hFFFE0001, 64'h00000001, 64'h08000);
        drive_exp(16'h8000, 16'h8000, 18'h30000, 18'h10000, 64'h40000000, 64'h40000000, 64'h30000);
        drive_exp(16'hFFFF, 16'h0001, 18'h30000, 18'h30000, 64'h0000FFFF, 64'hFFFFFFFF, 64'h10000);
        drive_exp(16'h0000, 16'h1234, 18'h1FFFF, 18'h1FFFF, 64'h00000000, 64'h00000000, 64'h3FFFC);
        drive_exp(16'h7FFF, 16'h8000, 18'h30000, 18'h00001, 64'h3FFF8000, 64'hC0008000, 64'h3FFFF);
        drain();

        for (int i = 0; i < 1000; i++) begin
            drive_one(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                      18'($urandom), 18'($urandom));
        end
        drain();

        for (int i = 0; i < 3; i++) begin
            drive_one(1'b1, 16'($urandom), 16'($urandom), 18'($urandom), 18'($urandom));
        end
        @(negedge clk);
        vin = 1'b0;
        #2 reset = 1'b1;
        #1;
        check_eq("midrst ov u0", {63'd0, ov_u0}, 64'd0);
        check_eq("midrst prod u0", {32'd0, p_u0}, 64'd0);
        check_eq("midrst ov s0", {63'd0, ov_s0}, 64'd0);
        check_eq("midrst prod s0", {32'd0, p_s0}, 64'd0);
        check_eq("midrst ov iir", {63'd0, ov_iir}, 64'd0);
        check_eq("midrst prod iir", {46'd0, p_iir}, 64'd0);
        check_eq("midrst ov r1", {63'd0, ov_r1}, 64'd0);
        check_eq("midrst prod r1", {32'd0, p_r1}, 64'd0);
        q_u0.delete(); q_s0.delete(); q_iir.delete(); q_r1.delete(); q_rw.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("post-reset quiet", {59'd0, ov_u0, ov_s0, ov_iir, ov_r1, ov_rw}, 64'd0);
        end

        drive_exp(16'hFFFF, 16'hFFFF, 18'h10000, 18'h08000, 64'hFFFE0001, 64'h00000001, 64'h08000);
        drive_one(1'b1, 16'h1234, 16'h5678, 18'h2ABCD, 18'h01234);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
